// File: rtl/debounce_pkg.sv
// Shared constants and elaboration helpers for the multi-channel debouncer.
// Pure compile-time content: no state, no latency.
package debounce_pkg;

    localparam int MODE_INTEGRATE = 0;
    localparam int MODE_STRETCH   = 1;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // STABLE_CNT-1 fits in CNT_W bits exactly when clog2(STABLE_CNT) <= CNT_W.
    function automatic bit params_ok(input int sync_stages, input int stable_cnt,
                                     input int cnt_w, input int mode);
        return (sync_stages >= 2) && (stable_cnt >= 1) && (cnt_w >= 1) &&
               ((mode == MODE_INTEGRATE) || (mode == MODE_STRETCH)) &&
               (clog2(stable_cnt) <= cnt_w);
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: synchroniser, stability counter, level and strobe registers.
// Level follows input SYNC_STAGES+STABLE_CNT enabled edges after capture (stretch: rise after SYNC_STAGES+1).
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CNT  = 50000,
    parameter int CNT_W       = 16,
    parameter int MODE        = MODE_INTEGRATE,
    parameter bit RESET_LEVEL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tick_en_i,
    input  logic sig_i,
    output logic sig_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(STABLE_CNT - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   lvl_q, lvl_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s;

    assign s      = sync_q[SYNC_STAGES-1];
    assign sync_d = {sync_q[SYNC_STAGES-2:0], sig_i};

    always_comb begin
        cnt_d  = cnt_q;
        lvl_d  = lvl_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s == lvl_q) begin
            cnt_d = '0;
        end else if ((MODE == MODE_STRETCH) && s) begin
            // Stretch asserts immediately; only the release is filtered.
            lvl_d  = 1'b1;
            rise_d = 1'b1;
            cnt_d  = '0;
        end else if (tick_en_i) begin
            if (cnt_q == TERM) begin
                lvl_d  = s;
                rise_d = s;
                fall_d = ~s;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
            cnt_q  <= '0;
            lvl_q  <= RESET_LEVEL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            lvl_q  <= lvl_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign sig_o  = lvl_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/debounce_n.sv
// CHANNELS independent debounce channels sharing one clock, reset and prescaler tick.
// Outputs registered; per-channel latency as in debounce_chan, no backpressure.
module debounce_n
    import debounce_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CNT  = 50000,
    parameter int CNT_W       = 16,
    parameter int MODE        = MODE_INTEGRATE,
    parameter bit RESET_LEVEL = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                tick_en_i,
    input  logic [CHANNELS-1:0] sig_i,
    output logic [CHANNELS-1:0] sig_o,
    output logic [CHANNELS-1:0] rise_o,
    output logic [CHANNELS-1:0] fall_o
);

    if (!params_ok(SYNC_STAGES, STABLE_CNT, CNT_W, MODE)) begin : g_bad_params
        $error("debounce_n: illegal SYNC_STAGES/STABLE_CNT/CNT_W/MODE combination");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        debounce_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .STABLE_CNT  (STABLE_CNT),
            .CNT_W       (CNT_W),
            .MODE        (MODE),
            .RESET_LEVEL (RESET_LEVEL)
        ) u_chan (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .tick_en_i (tick_en_i),
            .sig_i     (sig_i[i]),
            .sig_o     (sig_o[i]),
            .rise_o    (rise_o[i]),
            .fall_o    (fall_o[i])
        );
    end

endmodule

// File: tb/tb_debounce_n.sv
// Directed bench: integrate and stretch instances driven by the same inputs.
module tb_debounce_n;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_en;
    logic [3:0] sig;
    logic [3:0] out_i, rise_i, fall_i;
    logic [3:0] out_s, rise_s, fall_s;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    debounce_n #(.CHANNELS(4), .SYNC_STAGES(2), .STABLE_CNT(4), .CNT_W(16),
                 .MODE(0), .RESET_LEVEL(1'b0)) u_int (
        .clk_i(clk), .rst_ni(rst_n), .tick_en_i(tick_en), .sig_i(sig),
        .sig_o(out_i), .rise_o(rise_i), .fall_o(fall_i));

    debounce_n #(.CHANNELS(4), .SYNC_STAGES(2), .STABLE_CNT(4), .CNT_W(16),
                 .MODE(1), .RESET_LEVEL(1'b0)) u_str (
        .clk_i(clk), .rst_ni(rst_n), .tick_en_i(tick_en), .sig_i(sig),
        .sig_o(out_s), .rise_o(rise_s), .fall_o(fall_s));

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Advance one rising edge and land 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        tick_en = 1'b1;
        sig     = 4'hF;

        // Reset held with all inputs high, then released.
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("rst_out", {4'h0, out_i}, 8'h00);
            chk("rst_strobe", {rise_i, fall_i}, 8'h00);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("rel_out_e%0d", k), {4'h0, out_i}, (k >= 6) ? 8'h0F : 8'h00);
            chk($sformatf("rel_rise_e%0d", k), {4'h0, rise_i}, (k == 6) ? 8'h0F : 8'h00);
            chk($sformatf("rel_fall_e%0d", k), {4'h0, fall_i}, 8'h00);
        end

        // Channel 1 released; others must hold.
        sig = 4'hD;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("fall1_out_e%0d", k), {4'h0, out_i}, (k >= 6) ? 8'h0D : 8'h0F);
            chk($sformatf("fall1_str_e%0d", k), {rise_i, fall_i}, (k == 6) ? 8'h02 : 8'h00);
        end

        // Channel 0 released as well.
        sig = 4'hC;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("fall0_out_e%0d", k), {4'h0, out_i}, (k >= 6) ? 8'h0C : 8'h0D);
            chk($sformatf("fall0_str_e%0d", k), {rise_i, fall_i}, (k == 6) ? 8'h01 : 8'h00);
        end

        // Three-cycle glitch on channel 0 must be rejected.
        sig = 4'hD;
        step(); step(); step();
        sig = 4'hC;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("glitch_out_e%0d", k), {4'h0, out_i}, 8'h0C);
            chk($sformatf("glitch_str_e%0d", k), {rise_i, fall_i}, 8'h00);
        end
        // A held level afterwards needs the full stable time again.
        sig = 4'hD;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("reheld_out_e%0d", k), {4'h0, out_i}, (k >= 6) ? 8'h0D : 8'h0C);
            chk($sformatf("reheld_rise_e%0d", k), {4'h0, rise_i}, (k == 6) ? 8'h01 : 8'h00);
        end

        // Clean reset with inputs low before the prescale test.
        sig   = 4'h0;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step(); step(); step();
        chk("clr_out", {out_i, out_s}, 8'h00);

        // Prescaled: tick only on every 4th edge.
        sig = 4'h4;
        for (int k = 1; k <= 18; k++) begin
            tick_en = ((k % 4) == 0);
            step();
            chk($sformatf("pre_out_e%0d", k), {4'h0, out_i}, (k >= 16) ? 8'h04 : 8'h00);
            chk($sformatf("pre_rise_e%0d", k), {4'h0, rise_i}, (k == 16) ? 8'h04 : 8'h00);
        end
        tick_en = 1'b1;

        // Stretch: one-cycle pulse on channel 3.
        sig = 4'hC;
        step();
        sig = 4'h4;
        chk("str_e1_out", {4'h0, out_s}, 8'h04);
        for (int k = 2; k <= 9; k++) begin
            step();
            chk($sformatf("str_out_e%0d", k), {4'h0, out_s},
                ((k >= 3) && (k <= 6)) ? 8'h0C : 8'h04);
            chk($sformatf("str_rise_e%0d", k), {4'h0, rise_s}, (k == 3) ? 8'h08 : 8'h00);
            chk($sformatf("str_fall_e%0d", k), {4'h0, fall_s}, (k == 7) ? 8'h08 : 8'h00);
            chk($sformatf("str_int_e%0d", k), {rise_i, out_i}, 8'h04);
        end

        // Reset lands with channel 0 at count 3.
        sig = 4'h5;
        for (int k = 1; k <= 5; k++) step();
        chk("mid_pre_out", {4'h0, out_i}, 8'h04);
        rst_n = 1'b0;
        step();
        chk("mid_rst_out", {out_i, out_s}, 8'h00);
        chk("mid_rst_strobe", {rise_i, fall_i}, 8'h00);
        chk("mid_rst_strobe_s", {rise_s, fall_s}, 8'h00);
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("mid_out_e%0d", k), {4'h0, out_i}, (k >= 6) ? 8'h05 : 8'h00);
            chk($sformatf("mid_rise_e%0d", k), {rise_i, fall_i}, (k == 6) ? 8'h50 : 8'h00);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
